// File: rtl/cdma_desc_parser_if.sv
// Descriptor-fetch and command-issue bus between cdma_desc_parser and its neighbours.
// master: the parser (drives ll_req/ll_addr and the cmd_* payload).
// slave:  cmd_fetch plus the downstream command consumer.
interface cdma_desc_parser_if;
  logic        ll_req;
  logic [31:0] ll_addr;
  logic        ll_ack;
  logic        ll_dvld;
  logic [31:0] ll_rdata;
  logic [2:0]  ll_dcnt;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic [31:0] cmd_src_addr;
  logic [31:0] cmd_dst_addr;
  logic [15:0] cmd_len;
  logic        cmd_irq_en;
  logic        cmd_last;

  modport master (
    output ll_req, ll_addr,
    input  ll_ack, ll_dvld, ll_rdata, ll_dcnt,
    output cmd_vld, cmd_src_addr, cmd_dst_addr, cmd_len, cmd_irq_en, cmd_last,
    input  cmd_rdy
  );

  modport slave (
    input  ll_req, ll_addr,
    output ll_ack, ll_dvld, ll_rdata, ll_dcnt,
    input  cmd_vld, cmd_src_addr, cmd_dst_addr, cmd_len, cmd_irq_en, cmd_last,
    output cmd_rdy
  );
endinterface

// File: rtl/cdma_desc_parser.sv
// Linked-list descriptor walker: fetches 6-word descriptors through cmd_fetch,
// issues one DMA command per descriptor and follows next pointers until last.
// Optional build macro CDMA_DESC_CHK_EN: verify w5 against the XOR of w0..w4.
module cdma_desc_parser #(
  parameter int unsigned DESC_WORDS = 6
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [31:0]         start_addr,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                err,
  cdma_desc_parser_if.master  bus
);

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 16;
  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] LAST_IDX = CW'(DESC_WORDS - 1);

  typedef enum logic [2:0] {IDLE, REQ, RECV, ISSUE, DRAIN} state_e;

  state_e        state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          ll_req_q, ll_req_d;
  logic [AW-1:0] ll_addr_q, ll_addr_d;
  logic          cmd_vld_q, cmd_vld_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [LW-1:0] len_q, len_d;
  logic [AW-1:0] nxt_q, nxt_d;
  logic          last_q, last_d;
  logic          irq_q, irq_d;
`ifdef CDMA_DESC_CHK_EN
  logic [AW-1:0] chk_q, chk_d;
`endif

  logic last_word;
  assign last_word = bus.ll_dvld && (bus.ll_dcnt == LAST_IDX);

  // Next-state, field capture and registered-output updates
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    done_d    = 1'b0;
    ll_req_d  = ll_req_q;
    ll_addr_d = ll_addr_q;
    cmd_vld_d = cmd_vld_q;
    src_d     = src_q;
    dst_d     = dst_q;
    len_d     = len_q;
    nxt_d     = nxt_q;
    last_d    = last_q;
    irq_d     = irq_q;
`ifdef CDMA_DESC_CHK_EN
    chk_d     = chk_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (start_addr[1:0] != 2'b00) begin
            err_d = 1'b1;
          end else begin
            ll_addr_d = start_addr;
            err_d     = 1'b0;
            ll_req_d  = 1'b1;
            state_d   = REQ;
          end
        end
      end
      REQ: begin
        // An accepted fetch will still deliver its words, so abort must drain them
        if (bus.ll_ack) begin
          ll_req_d = 1'b0;
          state_d  = abort ? DRAIN : RECV;
`ifdef CDMA_DESC_CHK_EN
          chk_d    = '0;
`endif
        end else if (abort) begin
          ll_req_d = 1'b0;
          state_d  = IDLE;
        end
      end
      RECV: begin
        if (abort) begin
          state_d = last_word ? IDLE : DRAIN;
        end else if (bus.ll_dvld) begin
          case (bus.ll_dcnt)
            3'd0: src_d = bus.ll_rdata;
            3'd1: dst_d = bus.ll_rdata;
            3'd2: len_d = bus.ll_rdata[LW-1:0];
            3'd3: nxt_d = bus.ll_rdata;
            3'd4: begin
              last_d = bus.ll_rdata[0];
              irq_d  = bus.ll_rdata[1];
            end
            default: ;
          endcase
`ifdef CDMA_DESC_CHK_EN
          chk_d = chk_q ^ bus.ll_rdata;
`endif
          if (last_word) begin
`ifdef CDMA_DESC_CHK_EN
            if (chk_q != bus.ll_rdata) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              cmd_vld_d = 1'b1;
              state_d   = ISSUE;
            end
`else
            cmd_vld_d = 1'b1;
            state_d   = ISSUE;
`endif
          end
        end
      end
      ISSUE: begin
        if (abort) begin
          cmd_vld_d = 1'b0;
          state_d   = IDLE;
        end else if (bus.cmd_rdy) begin
          cmd_vld_d = 1'b0;
          if (last_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (nxt_q[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            ll_addr_d = nxt_q;
            ll_req_d  = 1'b1;
            state_d   = REQ;
          end
        end
      end
      DRAIN: begin
        if (last_word) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ll_req_q  <= 1'b0;
      ll_addr_q <= '0;
      cmd_vld_q <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      nxt_q     <= '0;
      last_q    <= 1'b0;
      irq_q     <= 1'b0;
`ifdef CDMA_DESC_CHK_EN
      chk_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ll_req_q  <= ll_req_d;
      ll_addr_q <= ll_addr_d;
      cmd_vld_q <= cmd_vld_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      nxt_q     <= nxt_d;
      last_q    <= last_d;
      irq_q     <= irq_d;
`ifdef CDMA_DESC_CHK_EN
      chk_q     <= chk_d;
`endif
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
  assign bus.ll_req       = ll_req_q;
  assign bus.ll_addr      = ll_addr_q;
  assign bus.cmd_vld      = cmd_vld_q;
  assign bus.cmd_src_addr = src_q;
  assign bus.cmd_dst_addr = dst_q;
  assign bus.cmd_len      = len_q;
  assign bus.cmd_irq_en   = irq_q;
  assign bus.cmd_last     = last_q;

endmodule

// File: tb/tb_cdma_desc_parser.sv
// Bench for cdma_desc_parser: memory-backed fetch responder, randomized
// back-pressure, and a chain-walk reference model over the descriptor memory.
module tb_cdma_desc_parser;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic        irq;
    logic        last;
  } cmd_t;

  logic        clk, rstn, start, abort;
  logic [31:0] start_addr;
  logic        busy, done, err;

  cdma_desc_parser_if bus ();

  cdma_desc_parser #(.DESC_WORDS(6)) dut (
    .clk(clk), .rstn(rstn), .start(start), .start_addr(start_addr),
    .abort(abort), .busy(busy), .done(done), .err(err), .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int ack_delay = -1;
  int bp_hold   = 0;
  logic [31:0] mem [logic [31:0]];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  // Writes one descriptor; w5 is the XOR of w0..w4, optionally corrupted
  function automatic void put_desc(input logic [31:0] a, input logic [31:0] w0, w1, w2, w3, w4,
                                   input bit corrupt);
    mem[a]       = w0;
    mem[a + 4]   = w1;
    mem[a + 8]   = w2;
    mem[a + 12]  = w3;
    mem[a + 16]  = w4;
    mem[a + 20]  = w0 ^ w1 ^ w2 ^ w3 ^ w4 ^ (corrupt ? 32'h0000_0100 : 32'h0);
  endfunction

  // Reference: walk the chain in memory following the descriptor rules
  cmd_t        exp_cmds[$];
  logic [31:0] exp_reqs[$];
  bit          exp_done, exp_err;
  function automatic void model_walk(input logic [31:0] sa);
    logic [31:0] a;
    logic [31:0] w [6];
    cmd_t c;
    exp_cmds.delete(); exp_reqs.delete(); exp_done = 0; exp_err = 0;
    if (sa[1:0] != 2'b00) begin exp_err = 1; return; end
    a = sa;
    for (int it = 0; it < 16; it++) begin
      exp_reqs.push_back(a);
      for (int k = 0; k < 6; k++) w[k] = rd(a + 32'(4 * k));
`ifdef CDMA_DESC_CHK_EN
      if (w[5] != (w[0] ^ w[1] ^ w[2] ^ w[3] ^ w[4])) begin exp_err = 1; return; end
`endif
      c.src = w[0]; c.dst = w[1]; c.len = w[2][15:0]; c.irq = w[4][1]; c.last = w[4][0];
      exp_cmds.push_back(c);
      if (w[4][0]) begin exp_done = 1; return; end
      if (w[3][1:0] != 2'b00) begin exp_err = 1; return; end
      a = w[3];
    end
  endfunction

  // Fetch responder standing in for cmd_fetch
  initial begin
    logic [31:0] a;
    bit alive;
    int d;
    bus.ll_ack = 0; bus.ll_dvld = 0; bus.ll_rdata = 0; bus.ll_dcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (rstn && bus.ll_req) begin
        a = bus.ll_addr;
        alive = 1;
        d = (ack_delay >= 0) ? ack_delay : int'($urandom_range(0, 3));
        repeat (d) begin
          @(posedge clk); #1;
          if (!bus.ll_req) alive = 0;
        end
        if (alive) begin
          bus.ll_ack = 1;
          @(posedge clk); #1;
          bus.ll_ack = 0;
          for (int w = 0; w < 6; w++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            bus.ll_dvld  = 1;
            bus.ll_dcnt  = 3'(w);
            bus.ll_rdata = rd(a + 32'(4 * w));
            @(posedge clk); #1;
            bus.ll_dvld  = 0;
          end
        end
      end
    end
  end

  // Monitor (negedge): fetch addresses, command handshakes, stability, done pulses
  cmd_t        obs_cmds[$];
  logic [31:0] obs_reqs[$];
  int          obs_runs[$];
  int done_cnt = 0, vld_cycles = 0, req_unstable = 0, cmd_unstable = 0;
  int vld_run = 0, hs_cyc = 0, done_cyc = 0;
  logic        prev_req = 0, prev_stall = 0;
  logic [31:0] prev_addr = 0;
  cmd_t        prev_cmd, cur_cmd;
  always @(negedge clk) begin
    cur_cmd = {bus.cmd_src_addr, bus.cmd_dst_addr, bus.cmd_len, bus.cmd_irq_en, bus.cmd_last};
    if (rstn) begin
      if (bus.ll_req && !prev_req) obs_reqs.push_back(bus.ll_addr);
      if (bus.ll_req && prev_req && bus.ll_addr !== prev_addr) req_unstable++;
      if (bus.cmd_vld && prev_stall && cur_cmd !== prev_cmd) cmd_unstable++;
      if (bus.cmd_vld) begin
        vld_cycles++;
        if (bus.cmd_rdy) begin
          obs_cmds.push_back(cur_cmd); obs_runs.push_back(vld_run);
          hs_cyc = cyc; vld_run = 0;
        end else vld_run++;
      end else vld_run = 0;
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
    prev_stall = bus.cmd_vld && !bus.cmd_rdy;
    prev_req   = bus.ll_req;
    prev_addr  = bus.ll_addr;
    prev_cmd   = cur_cmd;
  end

  // Downstream ready: random, or held low for bp_hold cycles of cmd_vld
  initial begin
    bus.cmd_rdy = 0;
    forever begin
      @(posedge clk); #1;
      bus.cmd_rdy = (bp_hold > 0) ? (vld_run >= bp_hold) : ($urandom_range(0, 2) != 0);
    end
  end

  int b_req, b_cmd, b_done, b_vld, b_ru, b_cu;
  task automatic snap();
    b_req = obs_reqs.size(); b_cmd = obs_cmds.size(); b_done = done_cnt;
    b_vld = vld_cycles; b_ru = req_unstable; b_cu = cmd_unstable;
  endtask

  task automatic do_start(input logic [31:0] a);
    @(posedge clk); #1; start = 1; start_addr = a;
    @(posedge clk); #1; start = 0;
  endtask

  task automatic wait_idle(output bit to);
    to = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) begin to = 0; break; end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, err, bus.ll_req, bus.cmd_vld} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {busy, done, err, bus.ll_req, bus.cmd_vld});
    else n_pass++;
    n_checks++;
    if ({bus.ll_addr, bus.cmd_src_addr, bus.cmd_dst_addr, bus.cmd_len, bus.cmd_irq_en, bus.cmd_last} !== 114'b0)
      $display("FAIL reset_data: ll_addr %h src %h dst %h len %h", bus.ll_addr, bus.cmd_src_addr, bus.cmd_dst_addr, bus.cmd_len);
    else n_pass++;
    @(posedge clk); #1; rstn = 1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single();
    bit to;
    cmd_t want;
    want = {32'h2000, 32'h3000, 16'h00FF, 1'b1, 1'b1};
    snap(); ack_delay = 2;
    put_desc(32'h1000, 32'h2000, 32'h3000, 32'h00FF, 32'h0, 32'h3, 0);
    @(posedge clk); #1; start = 1; start_addr = 32'h1000;
    @(posedge clk); #1; start = 0;
    n_checks++;
    if (!(bus.ll_req === 1'b1 && bus.ll_addr === 32'h1000 && busy === 1'b1))
      $display("FAIL single_req_latency: ll_req %b ll_addr %h busy %b want 1 00001000 1", bus.ll_req, bus.ll_addr, busy);
    else n_pass++;
    wait_idle(to); ack_delay = -1;
    n_checks++;
    if (to) $display("FAIL single_timeout: busy %b want 0", busy); else n_pass++;
    n_checks++;
    if (obs_cmds.size() - b_cmd !== 1) $display("FAIL single_cmd_count: got %0d want 1", obs_cmds.size() - b_cmd);
    else n_pass++;
    n_checks++;
    if (obs_cmds.size() > b_cmd && obs_cmds[b_cmd] !== want) $display("FAIL single_cmd: got %h want %h", obs_cmds[b_cmd], want);
    else n_pass++;
    n_checks++;
    if (done_cnt - b_done !== 1 || done_cyc - hs_cyc !== 1)
      $display("FAIL single_done: count %0d latency %0d want 1 1", done_cnt - b_done, done_cyc - hs_cyc);
    else n_pass++;
    n_checks++;
    if (err !== 1'b0) $display("FAIL single_err: got %b want 0", err); else n_pass++;
  endtask

  task automatic test_chain();
    bit to;
    snap();
    put_desc(32'h1000, 32'hA000, 32'hB000, 32'h0010, 32'h1040, 32'h2, 0);
    put_desc(32'h1040, 32'hC000, 32'hD000, 32'h1234_0020, 32'h0, 32'h1, 0);
    model_walk(32'h1000);
    do_start(32'h1000);
    wait_idle(to);
    n_checks++;
    if (to || obs_reqs.size() - b_req !== 2) $display("FAIL chain_reqs: timeout %0d count %0d want 0 2", to, obs_reqs.size() - b_req);
    else n_pass++;
    n_checks++;
    if (obs_reqs.size() > b_req + 1 && obs_reqs[b_req + 1] !== 32'h1040) $display("FAIL chain_second_addr: got %h want 00001040", obs_reqs[b_req + 1]);
    else n_pass++;
    n_checks++;
    if (obs_cmds.size() - b_cmd !== exp_cmds.size()) $display("FAIL chain_cmd_count: got %0d want %0d", obs_cmds.size() - b_cmd, exp_cmds.size());
    else n_pass++;
    for (int i = 0; i < exp_cmds.size(); i++) begin
      n_checks++;
      if (obs_cmds[b_cmd + i] !== exp_cmds[i]) $display("FAIL chain_cmd%0d: got %h want %h", i, obs_cmds[b_cmd + i], exp_cmds[i]);
      else n_pass++;
    end
    n_checks++;
    if (done_cnt - b_done !== 1 || err !== 1'b0) $display("FAIL chain_done: done %0d err %b want 1 0", done_cnt - b_done, err);
    else n_pass++;
  endtask

  task automatic test_back_pressure();
    bit to;
    snap(); bp_hold = 10;
    put_desc(32'h4000, 32'h1111_0000, 32'h2222_0000, 32'h0000_0FFF, 32'h0, 32'h1, 0);
    do_start(32'h4000);
    wait_idle(to); bp_hold = 0;
    n_checks++;
    if (to || obs_cmds.size() - b_cmd !== 1) $display("FAIL bp_handshakes: timeout %0d count %0d want 0 1", to, obs_cmds.size() - b_cmd);
    else n_pass++;
    n_checks++;
    if (cmd_unstable - b_cu !== 0) $display("FAIL bp_stable: got %0d changes want 0", cmd_unstable - b_cu);
    else n_pass++;
    n_checks++;
    if (vld_cycles - b_vld !== 11 || obs_runs[obs_runs.size() - 1] !== 10)
      $display("FAIL bp_hold_len: vld cycles %0d stall %0d want 11 10", vld_cycles - b_vld, obs_runs[obs_runs.size() - 1]);
    else n_pass++;
  endtask

  task automatic test_abort_recv();
    bit found, busy5;
    snap();
    put_desc(32'h5000, 32'h1, 32'h2, 32'h3, 32'h0, 32'h1, 0);
    do_start(32'h5000);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (bus.ll_dvld && bus.ll_dcnt == 3'd2) found = 1;
    end
    @(posedge clk); #1; abort = 1;
    @(posedge clk); #1; abort = 0;
    n_checks++;
    if (!found) $display("FAIL abort_word2_seen: got 0 want 1"); else n_pass++;
    found = 0; busy5 = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (bus.ll_dvld && bus.ll_dcnt == 3'd5) begin found = 1; busy5 = busy; end
    end
    @(negedge clk);
    n_checks++;
    if (!found || busy5 !== 1'b1 || busy !== 1'b0) $display("FAIL abort_drain: word5 %0d busy_at_w5 %b busy_after %b want 1 1 0", found, busy5, busy);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (vld_cycles - b_vld !== 0 || done_cnt - b_done !== 0 || err !== 1'b0)
      $display("FAIL abort_quiet: vld %0d done %0d err %b want 0 0 0", vld_cycles - b_vld, done_cnt - b_done, err);
    else n_pass++;
  endtask

  task automatic test_abort_issue();
    bit found;
    snap(); bp_hold = 100000;
    put_desc(32'h6000, 32'h10, 32'h20, 32'h30, 32'h0, 32'h1, 0);
    do_start(32'h6000);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (bus.cmd_vld) found = 1;
    end
    @(posedge clk); #1; abort = 1;
    @(posedge clk); #1; abort = 0;
    n_checks++;
    if (!found || bus.cmd_vld !== 1'b0 || busy !== 1'b0) $display("FAIL abort_issue: seen %0d cmd_vld %b busy %b want 1 0 0", found, bus.cmd_vld, busy);
    else n_pass++;
    repeat (3) @(negedge clk); bp_hold = 0;
    n_checks++;
    if (done_cnt - b_done !== 0 || obs_cmds.size() - b_cmd !== 0) $display("FAIL abort_issue_quiet: done %0d hs %0d want 0 0", done_cnt - b_done, obs_cmds.size() - b_cmd);
    else n_pass++;
  endtask

  task automatic test_misaligned();
    bit to;
    snap();
    put_desc(32'h1000, 32'h7000, 32'h8000, 32'h40, 32'h1042, 32'h0, 0);
    put_desc(32'h1040, 32'h9000, 32'h9100, 32'h50, 32'h0, 32'h1, 0);
    do_start(32'h1000);
    wait_idle(to);
    n_checks++;
    if (to || err !== 1'b1 || obs_cmds.size() - b_cmd !== 1) $display("FAIL misaligned_next: timeout %0d err %b cmds %0d want 0 1 1", to, err, obs_cmds.size() - b_cmd);
    else n_pass++;
    n_checks++;
    if (obs_reqs.size() - b_req !== 1 || done_cnt - b_done !== 0) $display("FAIL misaligned_no_refetch: reqs %0d done %0d want 1 0", obs_reqs.size() - b_req, done_cnt - b_done);
    else n_pass++;
    put_desc(32'h2000, 32'h1, 32'h2, 32'h3, 32'h0, 32'h1, 0);
    do_start(32'h2000);
    n_checks++;
    if (err !== 1'b0) $display("FAIL err_cleared_by_start: got %b want 0", err); else n_pass++;
    wait_idle(to);
    snap();
    do_start(32'h2002);
    repeat (3) @(negedge clk);
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0 || obs_reqs.size() - b_req !== 0)
      $display("FAIL misaligned_start: err %b busy %b reqs %0d want 1 0 0", err, busy, obs_reqs.size() - b_req);
    else n_pass++;
  endtask

  task automatic test_checksum();
    bit to;
    snap();
    put_desc(32'h7000, 32'hAAAA, 32'hBBBB, 32'h0C, 32'h0, 32'h1, 1);
    do_start(32'h7000);
    wait_idle(to);
`ifdef CDMA_DESC_CHK_EN
    n_checks++;
    if (to || err !== 1'b1 || vld_cycles - b_vld !== 0 || done_cnt - b_done !== 0)
      $display("FAIL checksum_bad: timeout %0d err %b vld %0d done %0d want 0 1 0 0", to, err, vld_cycles - b_vld, done_cnt - b_done);
    else n_pass++;
`else
    n_checks++;
    if (to || err !== 1'b0 || obs_cmds.size() - b_cmd !== 1 || done_cnt - b_done !== 1)
      $display("FAIL checksum_ignored: timeout %0d err %b cmds %0d done %0d want 0 0 1 1", to, err, obs_cmds.size() - b_cmd, done_cnt - b_done);
    else n_pass++;
`endif
  endtask

  task automatic test_random();
    bit to;
    logic [31:0] base, a, nxt, w4;
    int n;
    for (int it = 0; it < 20; it++) begin
      base = 32'h0001_0000 + 32'(it) * 32'h400;
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        a = base + 32'(k) * 32'h40;
        nxt = (k == n - 1) ? $urandom : a + 32'h40;
        if (k < n - 1 && $urandom_range(0, 9) == 0) nxt = nxt + 32'($urandom_range(1, 3));
        w4 = ($urandom & 32'hFFFF_FFFC) | {30'b0, 1'($urandom_range(0, 1)), 1'(k == n - 1)};
        put_desc(a, $urandom, $urandom, $urandom, nxt, w4, $urandom_range(0, 9) == 0);
      end
      model_walk(base);
      snap();
      do_start(base);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 15)) @(posedge clk);
        #1;
        if (busy) begin start = 1; start_addr = 32'h00F0_0000; @(posedge clk); #1; start = 0; end
      end
      wait_idle(to);
      n_checks++;
      if (to || obs_reqs.size() - b_req !== exp_reqs.size()) $display("FAIL rand%0d_req_count: timeout %0d got %0d want %0d", it, to, obs_reqs.size() - b_req, exp_reqs.size());
      else n_pass++;
      for (int i = 0; i < exp_reqs.size(); i++) begin
        n_checks++;
        if (obs_reqs[b_req + i] !== exp_reqs[i]) $display("FAIL rand%0d_req%0d: got %h want %h", it, i, obs_reqs[b_req + i], exp_reqs[i]);
        else n_pass++;
      end
      n_checks++;
      if (obs_cmds.size() - b_cmd !== exp_cmds.size()) $display("FAIL rand%0d_cmd_count: got %0d want %0d", it, obs_cmds.size() - b_cmd, exp_cmds.size());
      else n_pass++;
      for (int i = 0; i < exp_cmds.size(); i++) begin
        n_checks++;
        if (obs_cmds[b_cmd + i] !== exp_cmds[i]) $display("FAIL rand%0d_cmd%0d: got %h want %h", it, i, obs_cmds[b_cmd + i], exp_cmds[i]);
        else n_pass++;
      end
      n_checks++;
      if (done_cnt - b_done !== int'(exp_done) || err !== exp_err)
        $display("FAIL rand%0d_status: done %0d err %b want %0d %b", it, done_cnt - b_done, err, exp_done, exp_err);
      else n_pass++;
      n_checks++;
      if (req_unstable - b_ru !== 0 || cmd_unstable - b_cu !== 0)
        $display("FAIL rand%0d_stability: addr changes %0d cmd changes %0d want 0 0", it, req_unstable - b_ru, cmd_unstable - b_cu);
      else n_pass++;
    end
  endtask

  initial begin
    rstn = 0; start = 0; abort = 0; start_addr = 0;
    test_reset();
    test_single();
    test_chain();
    test_back_pressure();
    test_abort_recv();
    test_abort_issue();
    test_misaligned();
    test_checksum();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cdma_desc_parser.md
Name: cdma_desc_parser

Overview:
- Linked-list descriptor walker. It sits directly upstream of cmd_fetch and drives its ll_req/ll_addr, then consumes ll_dvld/ll_rdata/ll_dcnt.
- Assembles each 6-word descriptor into a DMA command, hands the command downstream over a valid/ready handshake, and follows the next pointer until a descriptor with the last flag is reached.

Parameters:
DESC_WORDS, 6, words per descriptor; must match the fixed cmd_fetch read length of 24 bytes.

Ports:
clk  input  1  clock
rstn  input  1  reset; asynchronous, active-low
start  input  1  one-cycle pulse; begin a chain walk at start_addr
start_addr  input  32  address of the first descriptor; must be 32-bit aligned
abort  input  1  one-cycle pulse; stop the walk
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse; chain completed normally
err  output  1  sticky error flag; cleared by an accepted start
ll_req  output  1  descriptor fetch request, to cmd_fetch
ll_addr  output  32  descriptor address, to cmd_fetch
ll_ack  input  1  fetch accepted
ll_dvld  input  1  descriptor word valid
ll_rdata  input  32  descriptor word
ll_dcnt  input  3  index of the current descriptor word
cmd_vld  output  1  command valid
cmd_rdy  input  1  command accepted
cmd_src_addr  output  32  source byte address
cmd_dst_addr  output  32  destination byte address
cmd_len  output  16  byte length, counted from 0
cmd_irq_en  output  1  raise an interrupt on completion of this command
cmd_last  output  1  this is the last descriptor of the chain

Behaviour:
- Reset values: all outputs 0; ll_addr 0; FSM in IDLE.
- Descriptor word layout, indexed by ll_dcnt:
  - w0: src address.
  - w1: dst address.
  - w2[15:0]: len.
  - w3: next pointer.
  - w4: bit0 = last, bit1 = irq_en.
  - w5: checksum; only checked when the optional feature is enabled.
- States: IDLE, REQ, RECV, ISSUE, DRAIN.
- IDLE:
  - start && !abort: ll_addr <= start_addr, err <= 0, go to REQ.
  - ll_req rises on the cycle after start.
  - start_addr[1:0] != 0: err <= 1, stay in IDLE.
- REQ:
  - ll_req held high until ll_req && ll_ack; then ll_req drops the next cycle and the FSM goes to RECV.
  - ll_addr is stable for the whole time ll_req is high.
- RECV:
  - On ll_dvld, capture ll_rdata into the field selected by ll_dcnt.
  - On ll_dvld with ll_dcnt == DESC_WORDS-1, go to ISSUE.
  - ll_dvld in IDLE or REQ is ignored.
- ISSUE:
  - cmd_vld is asserted the cycle after the 6th word is captured.
  - All cmd_* fields are registered and held stable while cmd_vld && !cmd_rdy.
  - On handshake with last=1: cmd_vld <= 0, done pulses for one cycle, go to IDLE.
  - On handshake with last=0:
    - next pointer [1:0] != 0: err <= 1, go to IDLE, no done.
    - otherwise: ll_addr <= next pointer, go to REQ.
- abort handling; abort has priority over start and over every other transition:
  - In REQ with no ack the same cycle: drop ll_req, go to IDLE.
  - In REQ with ll_ack the same cycle: go to DRAIN.
  - In RECV: go to DRAIN.
  - In ISSUE: drop cmd_vld, go to IDLE.
  - DRAIN discards data until ll_dvld with ll_dcnt == DESC_WORDS-1, then goes to IDLE.
  - No done pulse on abort; err is unchanged.
- start while busy is ignored.
- No chain length limit; a self-looping chain runs until abort.

Optional Feature:
- Macro: CDMA_DESC_CHK_EN.
- Defined: w5 must equal w0^w1^w2^w3^w4, computed as a running XOR during RECV.
  - On mismatch: no cmd_vld, err <= 1, go to IDLE.
- Undefined: w5 is discarded, no checksum logic is built, and err is set only by misaligned addresses.

Test Plan:
- Single descriptor: start at 0x1000, words {0x2000, 0x3000, 0x00FF, 0x0, 0x3, chk}, ack after 2 cycles.
  - Expect ll_req one cycle after start.
  - Expect cmd_vld with src=0x2000, dst=0x3000, len=0xFF, irq_en=1, last=1.
  - Expect done one cycle after cmd_rdy.
- Two-descriptor chain: descriptor 1 has next=0x1040 and last=0.
  - Expect a second ll_req with ll_addr=0x1040 after the first command handshake.
  - Expect two commands, then one done.
- Back-pressure: hold cmd_rdy=0 for 10 cycles.
  - Expect cmd_vld and all cmd_* fields stable throughout; exactly one handshake.
- Abort in RECV after word 2.
  - Expect remaining words drained, return to IDLE after word 5, no cmd_vld, no done, busy=0.
- Misaligned next pointer 0x1042 in descriptor 1.
  - Expect err=1 after the first handshake and no second ll_req.
  - A following start clears err.
- CDMA_DESC_CHK_EN defined, w5 corrupted.
  - Expect err=1, no cmd_vld, return to IDLE.
